// File: rtl/delay_sched.sv
// delay_sched: runtime-programmable delay line controller.
//
// Accepted words travel through a MAXDLY-stage register pipeline with a
// valid bit per stage and are tapped out at stage dly_cur, so latency is
// dly_cur ce-qualified cycles. A depth change stalls the input, lets the
// in-flight words drain at the old depth, loads the new depth and resumes.
//
// Optional build macro DELAY_SCHED_STATS_EN adds the out_cnt_o / drain_cnt_o
// statistics ports and their counters.
//
// Ports:
//   clk_i        clock, all state updates on posedge
//   rst_ni       asynchronous active-low reset
//   ce_i         clock enable; pipeline and FSM advance only when high
//   cfg_wr_i     depth update strobe (sampled when ce_i=1)
//   cfg_dly_i    requested depth (clamped to 1..MAXDLY)
//   in_vld_i     input word valid
//   in_dat_i     input word
//   in_rdy_o     input accepted when in_vld_i & in_rdy_o & ce_i
//   out_vld_o    output word valid
//   out_dat_o    output word
//   busy_o       depth change in progress
//   dly_cur_o    depth currently in effect
//   out_cnt_o    (stats) count of ce cycles with out_vld_o, wraps
//   drain_cnt_o  (stats) completed depth changes, saturates at 0xFF
module delay_sched #(
    parameter int unsigned WID     = 8,
    parameter int unsigned MAXDLY  = 8,
    parameter int unsigned DEF_DLY = 1
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           ce_i,
    input  logic           cfg_wr_i,
    input  logic [3:0]     cfg_dly_i,
    input  logic           in_vld_i,
    input  logic [WID-1:0] in_dat_i,
    output logic           in_rdy_o,
    output logic           out_vld_o,
    output logic [WID-1:0] out_dat_o,
    output logic           busy_o,
    output logic [3:0]     dly_cur_o
`ifdef DELAY_SCHED_STATS_EN
    ,
    output logic [15:0]    out_cnt_o,
    output logic [7:0]     drain_cnt_o
`endif
);

    localparam logic [3:0] MaxDly = 4'(MAXDLY);
    localparam logic [3:0] DefDly = 4'(DEF_DLY);

    typedef enum logic [1:0] {StRun, StDrain, StLoad} state_e;

    state_e                      state_q, state_d;
    logic [3:0]                  dly_cur_q, dly_cur_d;
    logic [3:0]                  pending_q, pending_d;
    logic [MAXDLY:1]             v_q, v_d;
    logic [MAXDLY:1][WID-1:0]    s_q, s_d;
    logic [3:0]                  cfg_clamped;
    logic                        live;

    always_comb begin
        cfg_clamped = cfg_dly_i;
        if (cfg_dly_i == 4'd0) begin
            cfg_clamped = 4'd1;
        end else if (cfg_dly_i > MaxDly) begin
            cfg_clamped = MaxDly;
        end
    end

    // Any valid word still inside the active part of the pipeline.
    always_comb begin
        live = 1'b0;
        for (int k = 1; k <= int'(MAXDLY); k++) begin
            if (k <= int'(dly_cur_q)) begin
                live = live | v_q[k];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        dly_cur_d = dly_cur_q;
        in_rdy_o  = 1'b0;
        busy_o    = 1'b1;
        unique case (state_q)
            StRun: begin
                in_rdy_o = 1'b1;
                busy_o   = 1'b0;
                if (cfg_wr_i && (cfg_clamped != dly_cur_q)) begin
                    pending_d = cfg_clamped;
                    state_d   = StDrain;
                end
            end
            StDrain: begin
                if (cfg_wr_i) begin
                    pending_d = cfg_clamped;
                end
                if (!live) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                dly_cur_d = pending_q;
                state_d   = StRun;
            end
            default: state_d = StRun;
        endcase
    end

    // Shift; stages beyond the active depth are kept invalid so a later
    // depth increase never exposes stale words.
    always_comb begin
        s_d = s_q;
        v_d = v_q;
        for (int k = 1; k <= int'(MAXDLY); k++) begin
            if (k == 1) begin
                s_d[k] = in_dat_i;
                v_d[k] = in_vld_i & in_rdy_o;
            end else begin
                s_d[k] = s_q[k-1];
                v_d[k] = v_q[k-1];
            end
            if (k > int'(dly_cur_q)) begin
                v_d[k] = 1'b0;
            end
        end
        if (state_q == StLoad) begin
            v_d = '0;
        end
    end

    always_comb begin
        out_vld_o = 1'b0;
        out_dat_o = '0;
        for (int k = 1; k <= int'(MAXDLY); k++) begin
            if (k == int'(dly_cur_q)) begin
                out_vld_o = v_q[k];
                out_dat_o = s_q[k];
            end
        end
    end

    assign dly_cur_o = dly_cur_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StRun;
            dly_cur_q <= DefDly;
            pending_q <= DefDly;
            v_q       <= '0;
            s_q       <= '0;
        end else if (ce_i) begin
            state_q   <= state_d;
            dly_cur_q <= dly_cur_d;
            pending_q <= pending_d;
            v_q       <= v_d;
            s_q       <= s_d;
        end
    end

`ifdef DELAY_SCHED_STATS_EN
    logic [15:0] out_cnt_q;
    logic [7:0]  drain_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_cnt_q   <= 16'd0;
            drain_cnt_q <= 8'd0;
        end else if (ce_i) begin
            if (out_vld_o) begin
                out_cnt_q <= out_cnt_q + 16'd1;
            end
            if ((state_q == StLoad) && (drain_cnt_q != 8'hFF)) begin
                drain_cnt_q <= drain_cnt_q + 8'd1;
            end
        end
    end

    assign out_cnt_o   = out_cnt_q;
    assign drain_cnt_o = drain_cnt_q;
`endif

endmodule
